// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - MM:SS packed-BCD up/down counter with debounced start/clear buttons.

module bcd_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_prev_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            if (sync2_q != level_q) begin
                if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // High for the single cycle after the debounced level has risen.
    assign press_o = level_q & ~level_prev_q;
endmodule

module bcd_time_counter #(
    parameter int TICK_DIV     = 100000000,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start_i,
    input  logic       btn_clear_i,
    input  logic       dir_i,
    input  logic       load_i,
    input  logic [7:0] load_min_i,
    input  logic [7:0] load_sec_i,
    output logic [7:0] min_o,
    output logic [7:0] sec_o,
    output logic       running_o,
    output logic       done_o,
    output logic       wrap_o
);
    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t        state_q;
    logic [7:0]    min_q;
    logic [7:0]    sec_q;
    logic [TW-1:0] tick_q;
    logic          running_q;
    logic          done_q;
    logic          wrap_q;
    logic          start_p;
    logic          clear_p;
    logic [15:0]   time_up_d;
    logic [15:0]   time_dn_d;
    logic          load_ok;
    logic          time_zero;

    bcd_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_start (
        .clk(clk), .rst_n(rst_n), .btn_i(btn_start_i), .press_o(start_p)
    );
    bcd_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clear (
        .clk(clk), .rst_n(rst_n), .btn_i(btn_clear_i), .press_o(clear_p)
    );

    function automatic logic [15:0] bcd_up(input logic [15:0] t);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = t;
        if (su != 4'd9) su = su + 4'd1;
        else begin
            su = 4'd0;
            if (st != 4'd5) st = st + 4'd1;
            else begin
                st = 4'd0;
                if (mu != 4'd9) mu = mu + 4'd1;
                else begin
                    mu = 4'd0;
                    mt = (mt != 4'd9) ? mt + 4'd1 : 4'd0;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    function automatic logic [15:0] bcd_dn(input logic [15:0] t);
        logic [3:0] mt, mu, st, su;
        {mt, mu, st, su} = t;
        if (su != 4'd0) su = su - 4'd1;
        else begin
            su = 4'd9;
            if (st != 4'd0) st = st - 4'd1;
            else begin
                st = 4'd5;
                if (mu != 4'd0) mu = mu - 4'd1;
                else begin
                    mu = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mu, st, su};
    endfunction

    assign time_up_d = bcd_up({min_q, sec_q});
    assign time_dn_d = bcd_dn({min_q, sec_q});
    assign time_zero = ({min_q, sec_q} == 16'h0000);
    assign load_ok   = (load_min_i[7:4] <= 4'd9) && (load_min_i[3:0] <= 4'd9) &&
                       (load_sec_i[7:4] <= 4'd5) && (load_sec_i[3:0] <= 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            min_q     <= 8'h00;
            sec_q     <= 8'h00;
            tick_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            if (clear_p) begin
                state_q   <= S_IDLE;
                min_q     <= 8'h00;
                sec_q     <= 8'h00;
                tick_q    <= '0;
                running_q <= 1'b0;
            end else if (load_i && state_q != S_RUN) begin
                if (load_ok) begin
                    min_q <= load_min_i;
                    sec_q <= load_sec_i;
                    if (state_q == S_DONE) state_q <= S_IDLE;
                end
            end else if (start_p) begin
                case (state_q)
                    S_IDLE: if (!(dir_i && time_zero)) begin
                        state_q   <= S_RUN;
                        tick_q    <= '0;
                        running_q <= 1'b1;
                    end
                    S_RUN: begin
                        state_q   <= S_PAUSE;
                        running_q <= 1'b0;
                    end
                    S_PAUSE: begin
                        state_q   <= S_RUN;
                        tick_q    <= '0;
                        running_q <= 1'b1;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (state_q == S_RUN) begin
                if (tick_q == TW'(TICK_DIV - 1)) begin
                    tick_q <= '0;
                    if (!dir_i) begin
                        {min_q, sec_q} <= time_up_d;
                        wrap_q         <= (time_up_d == 16'h0000);
                    end else if (!time_zero) begin
                        {min_q, sec_q} <= time_dn_d;
                        if (time_dn_d == 16'h0000) begin
                            done_q    <= 1'b1;
                            state_q   <= S_DONE;
                            running_q <= 1'b0;
                        end
                    end
                end else begin
                    tick_q <= tick_q + 1'b1;
                end
            end
        end
    end

    assign min_o     = min_q;
    assign sec_o     = sec_q;
    assign running_o = running_q;
    assign done_o    = done_q;
    assign wrap_o    = wrap_q;
endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - directed self-checking bench for bcd_time_counter.

module tb_bcd_time_counter;
    logic       clk;
    logic       rst_n;
    logic       btn_start_i;
    logic       btn_clear_i;
    logic       dir_i;
    logic       load_i;
    logic [7:0] load_min_i;
    logic [7:0] load_sec_i;
    logic [7:0] min_o;
    logic [7:0] sec_o;
    logic       running_o;
    logic       done_o;
    logic       wrap_o;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_time_counter #(.TICK_DIV(4), .DEBOUNCE_CYC(3)) dut (
        .clk(clk), .rst_n(rst_n), .btn_start_i(btn_start_i), .btn_clear_i(btn_clear_i),
        .dir_i(dir_i), .load_i(load_i), .load_min_i(load_min_i), .load_sec_i(load_sec_i),
        .min_o(min_o), .sec_o(sec_o), .running_o(running_o), .done_o(done_o), .wrap_o(wrap_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_run(input string tag, input logic val);
        int i;
        i = 0;
        while (running_o !== val && i < 30) begin
            @(negedge clk);
            i++;
        end
        check(tag, {31'd0, running_o}, {31'd0, val});
    endtask

    task automatic press_btn(input bit clr);
        if (clr) btn_clear_i = 1'b1; else btn_start_i = 1'b1;
        repeat (8) @(negedge clk);
        if (clr) btn_clear_i = 1'b0; else btn_start_i = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] m, input logic [7:0] s);
        load_i     = 1'b1;
        load_min_i = m;
        load_sec_i = s;
        @(negedge clk);
        load_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; btn_start_i = 1'b0; btn_clear_i = 1'b0;
        dir_i = 1'b0; load_i = 1'b0; load_min_i = 8'h00; load_sec_i = 8'h00;
        repeat (3) @(negedge clk);
        check("reset", {13'd0, min_o, sec_o, running_o, done_o, wrap_o}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two-cycle glitch must not get through the debouncer.
        btn_start_i = 1'b1;
        repeat (2) @(negedge clk);
        btn_start_i = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_idle", {23'd0, running_o, min_o}, 32'd0);

        btn_start_i = 1'b1;
        wait_run("hold_start", 1'b1);
        repeat (4) @(negedge clk);
        btn_start_i = 1'b0;
        repeat (10) @(negedge clk);
        check("release_no_pulse", {31'd0, running_o}, 32'd1);
        press_btn(1'b1);
        check("clear_after_hold", {15'd0, min_o, sec_o, running_o}, 32'd0);

        // Up-count wrap 99:58 -> 99:59 -> 00:00.
        do_load(8'h99, 8'h58);
        check("load_9958", {16'd0, min_o, sec_o}, 32'h9958);
        dir_i = 1'b0;
        btn_start_i = 1'b1;
        wait_run("up_run", 1'b1);
        btn_start_i = 1'b0;
        repeat (3) @(negedge clk);
        check("up_pre_tick", {16'd0, min_o, sec_o}, 32'h9958);
        @(negedge clk);
        check("up_tick1", {16'd0, min_o, sec_o}, 32'h9959);
        repeat (3) @(negedge clk);
        check("up_pre_wrap", {15'd0, min_o, sec_o, wrap_o}, {15'd0, 16'h9959, 1'b0});
        @(negedge clk);
        check("up_wrap", {14'd0, min_o, sec_o, wrap_o, running_o}, {14'd0, 16'h0000, 2'b11});
        @(negedge clk);
        check("wrap_one_cycle", {30'd0, wrap_o, running_o}, 32'd1);
        press_btn(1'b1);

        // Down-count 01:00 to 00:00.
        do_load(8'h01, 8'h00);
        dir_i = 1'b1;
        btn_start_i = 1'b1;
        wait_run("dn_run", 1'b1);
        btn_start_i = 1'b0;
        repeat (4) @(negedge clk);
        check("dn_0059", {16'd0, min_o, sec_o}, 32'h0059);
        repeat (232) @(negedge clk);
        check("dn_0001", {15'd0, min_o, sec_o, running_o}, {15'd0, 16'h0001, 1'b1});
        repeat (3) @(negedge clk);
        check("dn_pre_done", {15'd0, min_o, sec_o, done_o}, {15'd0, 16'h0001, 1'b0});
        @(negedge clk);
        check("dn_done", {14'd0, min_o, sec_o, done_o, running_o}, {14'd0, 16'h0000, 2'b10});
        @(negedge clk);
        check("done_one_cycle", {30'd0, done_o, running_o}, 32'd0);
        press_btn(1'b0);
        check("done_to_idle", {15'd0, min_o, sec_o, running_o}, 32'd0);
        press_btn(1'b0);
        check("idle_zero_down_stays", {31'd0, running_o}, 32'd0);
        dir_i = 1'b0;
        press_btn(1'b0);
        check("idle_start_up", {31'd0, running_o}, 32'd1);
        press_btn(1'b1);

        // Pause freezes time; loads accepted in PAUSE, ignored in RUN.
        press_btn(1'b0);
        check("run_again", {31'd0, running_o}, 32'd1);
        press_btn(1'b0);
        check("paused", {31'd0, running_o}, 32'd0);
        do_load(8'h12, 8'h34);
        check("load_in_pause", {16'd0, min_o, sec_o}, 32'h1234);
        repeat (20) @(negedge clk);
        check("pause_frozen", {15'd0, min_o, sec_o, running_o}, {15'd0, 16'h1234, 1'b0});
        do_load(8'h12, 8'h60);
        check("load_bad_sec", {16'd0, min_o, sec_o}, 32'h1234);
        press_btn(1'b0);
        check("resume", {31'd0, running_o}, 32'd1);
        do_load(8'h00, 8'h00);
        check("load_in_run_ignored", {24'd0, min_o}, 32'h12);
        press_btn(1'b1);

        // Clear and start debounced in the same cycle while running.
        do_load(8'h05, 8'h07);
        btn_start_i = 1'b1;
        wait_run("clr_pri_run", 1'b1);
        btn_start_i = 1'b0;
        repeat (6) @(negedge clk);
        btn_start_i = 1'b1;
        btn_clear_i = 1'b1;
        wait_run("clr_pri_stop", 1'b0);
        check("clr_pri_time", {16'd0, min_o, sec_o}, 32'h0000);
        btn_start_i = 1'b0;
        btn_clear_i = 1'b0;
        repeat (8) @(negedge clk);
        check("clr_pri_idle", {15'd0, min_o, sec_o, running_o}, 32'd0);

        // Asynchronous reset mid-count, away from the clock edge.
        do_load(8'h03, 8'h21);
        btn_start_i = 1'b1;
        wait_run("rst_run", 1'b1);
        btn_start_i = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst", {13'd0, min_o, sec_o, running_o, done_o, wrap_o}, 32'd0);
        @(negedge clk);
        check("rst_hold", {13'd0, min_o, sec_o, running_o, done_o, wrap_o}, 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_idle", {13'd0, min_o, sec_o, running_o, done_o, wrap_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
- Producer side of the min:sec display path.
- Keeps an MM:SS time in packed BCD and counts up or down once per second.
- Accepts start/stop and clear from raw board push-buttons, which it debounces internally.
- Accepts a preset load from surrounding logic.
- min_o/sec_o feed the seven-segment multiplexer directly, tens digit in [7:4], units digit in [3:0].

Parameters:
- TICK_DIV, 100000000, clk cycles per one-second tick (>=2).
- DEBOUNCE_CYC, 1000000, consecutive stable synchronised cycles required to accept a button level change (>=1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- btn_start_i  input  1  raw start/stop button, active-high, asynchronous.
- btn_clear_i  input  1  raw clear button, active-high, asynchronous.
- dir_i  input  1  count direction: 0 = up, 1 = down; synchronous, sampled at each tick.
- load_i  input  1  synchronous one-cycle preset strobe.
- load_min_i  input  8  preset minutes, BCD.
- load_sec_i  input  8  preset seconds, BCD.
- min_o  output  8  current minutes, BCD 00..99.
- sec_o  output  8  current seconds, BCD 00..59.
- running_o  output  1  high in RUN state.
- done_o  output  1  one-cycle pulse when a down-count reaches 00:00.
- wrap_o  output  1  one-cycle pulse when an up-count rolls 99:59 -> 00:00.

Behaviour:
- Reset (rst_n low, async): min_o=8'h00, sec_o=8'h00, running_o=0, done_o=0, wrap_o=0, state IDLE, tick counter 0, debouncers cleared with debounced level 0.
- Button path, per button:
  - 2-FF synchroniser.
  - Debounce counter: debounced level takes the synchronised value once it has differed from the current debounced level for DEBOUNCE_CYC consecutive cycles. Any agreement resets the count.
  - Press pulse (one cycle) is asserted the cycle after the debounced level rises. Release generates nothing.
- States: IDLE, RUN, PAUSE, DONE. Priority each cycle: clear > load > start.
- Clear press: any state -> IDLE; time forced to 00:00; tick counter cleared; same cycle as the clear pulse, visible next cycle.
- Load (load_i=1):
  - Accepted only in IDLE, PAUSE or DONE. Ignored in RUN.
  - Rejected with no change if any digit is invalid: minute digit >9, sec tens >5, sec units >9.
  - Accepted load updates outputs next cycle and moves DONE -> IDLE; IDLE and PAUSE keep their state.
- Start press:
  - IDLE -> RUN.
  - RUN -> PAUSE.
  - PAUSE -> RUN.
  - DONE -> IDLE, time unchanged.
  - Exception: IDLE with dir_i=1 and time 00:00 stays IDLE.
- Tick counter:
  - Cleared on every entry to RUN; counts 0..TICK_DIV-1 only in RUN; frozen in PAUSE.
  - Tick fires on the cycle the counter equals TICK_DIV-1, then the counter wraps to 0.
  - First time change is therefore visible TICK_DIV cycles after the RUN entry cycle.
- Up-count on tick:
  - sec units 9 -> 0 with carry; sec tens 5 -> 0 with carry into minutes; min units 9 -> 0 with carry; min tens 9 -> 0.
  - 99:59 -> 00:00 pulses wrap_o for one cycle (same cycle the new value appears) and stays in RUN.
- Down-count on tick:
  - Mirror borrow: sec 00 -> 59 with borrow; min units 0 -> 9.
  - Transition to 00:00 pulses done_o in the cycle 00:00 appears and moves to DONE, running_o=0.
  - Never decrements below 00:00.
- dir_i may change while running; it takes effect at the next tick.
- Clear and start pressed in the same cycle: clear wins, start is discarded.
- Reset mid-count: immediate return to reset values; no done_o or wrap_o pulse.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
(Use TICK_DIV=4, DEBOUNCE_CYC=3.)
- Debounce: btn_start_i glitch high for 2 cycles then low -> no state change. Held high 10 cycles -> exactly one start pulse, running_o=1, and a later release produces no pulse.
- Up-count wrap: load 99:58 in IDLE, start, dir_i=0 -> 99:59 at 4 cycles after RUN entry, 00:00 after 8 cycles with wrap_o high one cycle, running_o stays 1.
- Down-count finish: load 01:00, dir_i=1, start -> 00:59 after first tick, 00:00 after 60 ticks, done_o one cycle, running_o=0 (DONE). A further start press -> IDLE with time 00:00.
- Pause/load rules:
  - Start, then start again -> PAUSE, time frozen for 20 cycles.
  - load_i with load_min_i=8'h12, load_sec_i=8'h34 -> 12:34.
  - load_sec_i=8'h60 -> rejected.
  - load_i during RUN -> ignored.
- Clear priority: clear and start debounced presses in the same cycle while in RUN at 05:07 -> IDLE, 00:00, running_o=0.
- Async reset: assert rst_n low mid-RUN at 03:21, away from a clk edge -> outputs 00:00, all flags 0 immediately, no done_o or wrap_o pulse. Stay IDLE after release.
